// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART console: register offsets,
// STATUS bit positions and the RX/TX state encodings.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Receive FIFO. A pop on an empty FIFO is ignored; a push into a full FIFO
// succeeds only when a pop frees the head slot at the same edge.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses <= so every reader sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_console.sv
// CPU-mapped 8N1 UART console with an RX FIFO. Define UART_CONSOLE_IRQ_EN to
// enable the CTRL register and the registered interrupt output.
module uart_console
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 7080000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       we_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       irq_o
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CW    = $clog2(DIV + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic rd_en, data_rd, status_rd, data_wr;
  assign rd_en     = en_i & ~we_i;
  assign data_rd   = rd_en && (addr_i == ADDR_DATA);
  assign status_rd = rd_en && (addr_i == ADDR_STATUS);
  assign data_wr   = en_i && we_i && (addr_i == ADDR_DATA);

  // ---------------- RX path ----------------
  logic [1:0]    rx_sync;
  logic          rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push;
  logic          frame_evt;
  logic          rx_s;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_sync   <= 2'b11;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], rx_i};
      rx_prev   <= rx_s;
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(DIV - 1)) begin
            rx_cnt    <= '0;
            rx_state  <= RX_IDLE;
            rx_push   <= rx_s;
            frame_evt <= ~rx_s;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and flags ----------------
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             rx_avail, rx_full;
  logic             overrun, frame_err, overrun_evt;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (rx_push),
    .pop     (data_rd),
    .din     (rx_shift),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_avail    = (fifo_count != '0);
  assign rx_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign overrun_evt = rx_push & fifo_full & ~data_rd;

  // A set event on the same edge as a STATUS read wins over the clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_evt | (overrun   & ~status_rd);
      frame_err <= frame_evt   | (frame_err & ~status_rd);
    end
  end

  // ---------------- TX path ----------------
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_o     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (data_wr) begin
            tx_state <= TX_START;
            tx_shift <= din_i;
            tx_cnt   <= '0;
            tx_o     <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
            tx_o     <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_o     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_o     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- CTRL and interrupt ----------------
  logic [7:0] ctrl_val;

`ifdef UART_CONSOLE_IRQ_EN
  logic rx_ie, tx_ie;

  assign ctrl_val = {6'b0, tx_ie, rx_ie};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (en_i && we_i && (addr_i == ADDR_CTRL)) begin
        rx_ie <= din_i[0];
        tx_ie <= din_i[1];
      end
      irq_o <= (rx_ie & rx_avail) | (tx_ie & ~tx_busy);
    end
  end
`else
  assign ctrl_val = 8'h00;
  assign irq_o    = 1'b0;
`endif

  // ---------------- Register read ----------------
  logic [7:0] status;
  logic [7:0] rd_val;

  always_comb begin
    status               = 8'h00;
    status[ST_RX_AVAIL]  = rx_avail;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_OVERRUN]   = overrun;
    status[ST_FRAME_ERR] = frame_err;
  end

  // NOTE: default assignment first so no path leaves rd_val unassigned (no latch).
  always_comb begin
    rd_val = 8'h00;
    case (addr_i)
      ADDR_DATA:   rd_val = fifo_empty ? 8'h00 : fifo_head;
      ADDR_STATUS: rd_val = status;
      ADDR_CTRL:   rd_val = ctrl_val;
      default:     rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   dout_o <= 8'h00;
    else if (rd_en) dout_o <= rd_val;
  end

endmodule

// File: tb/tb_uart_console.sv
// Self-checking bench for uart_console: randomized serial traffic against a
// queue-based model of the RX FIFO and flags, plus TX waveform checks.
module tb_uart_console;

  localparam int CLK_HZ = 7080000;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rx = 1'b1;
  logic       tx;
  logic       irq;

  int checks = 0;
  int errors = 0;

  // Reference model: received bytes waiting to be read, plus sticky flags.
  logic [7:0] model_q[$];
  bit         m_overrun = 0;
  bit         m_frame_err = 0;

  uart_console #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (en),
    .we_i    (we),
    .addr_i  (addr),
    .din_i   (din),
    .dout_o  (dout),
    .rx_i    (rx),
    .tx_o    (tx),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_status(input bit busy);
    logic [7:0] s;
    s = 8'h00;
    s[0] = (model_q.size() != 0);
    s[1] = (model_q.size() == DEPTH);
    s[2] = busy;
    s[3] = m_overrun;
    s[4] = m_frame_err;
    return s;
  endfunction

  function automatic logic [7:0] model_pop();
    if (model_q.size() == 0) return 8'h00;
    return model_q.pop_front();
  endfunction

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = dout;
    en = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  // Drives one 8N1 frame on rx and updates the model with its outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    if (!stop)                        m_frame_err = 1;
    else if (model_q.size() < DEPTH)  model_q.push_back(b);
    else                              m_overrun = 1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h00 || tx !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%02h tx=%b irq=%b expected 00 1 0", dout, tx, irq);
    end
    rst_n = 1'b1;
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %02h expected 00", d); end
    cpu_read(A_DATA, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", d); end
    cpu_write(A_RSVD, 8'hFF);
    cpu_read(A_RSVD, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reserved_reg: got %02h expected 00", d); end
  endtask

  task automatic test_tx(input logic [7:0] b, input string tag);
    logic [7:0] st;
    logic       exp_bit;
    logic       got_bit;
    int         bad_at;
    cpu_write(A_DATA, b);
    for (int i = 0; i < 10; i++) begin
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      bad_at  = -1;
      got_bit = exp_bit;
      for (int j = 0; j < DIV; j++) begin
        if (tx !== exp_bit && bad_at < 0) begin bad_at = j; got_bit = tx; end
        @(negedge clk);
      end
      checks++;
      if (bad_at >= 0) begin
        errors++;
        $display("FAIL %s bit%0d: tx_o=%b at cycle %0d expected %b", tag, i, got_bit, bad_at, exp_bit);
      end
    end
    cpu_read(A_STATUS, st);
    checks++;
    if (st !== model_status(0)) begin
      errors++;
      $display("FAIL %s status_after: got %02h expected %02h", tag, st, model_status(0));
    end
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [7:0] st;
    bit         done;
    done = 0;
    for (int k = 0; k < 800 && !done; k++) begin
      cpu_read(A_STATUS, st);
      if (!st[2]) done = 1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s: tx_busy=1 after timeout expected 0", tag); end
  endtask

  task automatic test_tx_busy();
    logic [7:0] st;
    int         low_seen;
    cpu_write(A_DATA, 8'($urandom));
    cpu_read(A_STATUS, st);
    checks++;
    if (st !== model_status(1)) begin
      errors++;
      $display("FAIL tx_busy_status: got %02h expected %02h", st, model_status(1));
    end
    cpu_write(A_DATA, 8'h00);
    wait_tx_idle("tx_busy_clear");
    low_seen = 0;
    repeat (2 * DIV) begin
      if (tx !== 1'b1) low_seen++;
      @(negedge clk);
    end
    checks++;
    if (low_seen != 0) begin
      errors++;
      $display("FAIL tx_discard: tx_o low for %0d cycles expected 0", low_seen);
    end
  endtask

  task automatic test_back_to_back();
    cpu_write(A_DATA, 8'($urandom));
    wait_tx_idle("b2b_first");
    test_tx(8'($urandom), "b2b_second");
  endtask

  task automatic test_rx_basic();
    logic [7:0] d;
    logic [7:0] e;
    send_frame(8'hA3, 1);
    cpu_read(A_STATUS, d);
    e = model_status(0);
    checks++;
    if (d !== e || d !== 8'h01) begin errors++; $display("FAIL rx_status: got %02h expected %02h", d, e); end
    cpu_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL rx_data: got %02h expected %02h", d, e); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rx_status_empty: got %02h expected 00", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h0B) begin errors++; $display("FAIL overrun_status: got %02h expected 0B", d); end
    m_overrun = 0;
    for (int i = 0; i < 9; i++) begin
      cpu_read(A_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin errors++; $display("FAIL overrun_read%0d: got %02h expected %02h", i, d, e); end
    end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL overrun_cleared: got %02h expected 00", d); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_frame(8'h7E, 0);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL frame_err_status: got %02h expected 10", d); end
    m_frame_err = 0;
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL frame_err_cleared: got %02h expected 00", d); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL glitch_status: got %02h expected 00", d); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] e;
    int         n;
    int         reads;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) send_frame(8'($urandom), $urandom_range(0, 4) != 0);
      cpu_read(A_STATUS, d);
      e = model_status(0);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rand%0d_status: got %02h expected %02h", r, d, e); end
      m_overrun = 0;
      m_frame_err = 0;
      reads = model_q.size() + 1;
      for (int i = 0; i < reads; i++) begin
        cpu_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL rand%0d_read%0d: got %02h expected %02h", r, i, d, e); end
      end
    end
  endtask

  task automatic test_ctrl_irq();
    logic [7:0] d;
    logic [7:0] e;
`ifdef UART_CONSOLE_IRQ_EN
    cpu_write(A_CTRL, 8'h01);
    cpu_read(A_CTRL, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL ctrl_read: got %02h expected 01", d); end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
    send_frame(8'h42, 1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b expected 1", irq); end
    cpu_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL irq_data: got %02h expected %02h", d, e); end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_read: got %b expected 0", irq); end
    cpu_write(A_CTRL, 8'h02);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_idle: got %b expected 1", irq); end
    cpu_write(A_CTRL, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b expected 0", irq); end
`else
    cpu_write(A_CTRL, 8'h03);
    cpu_read(A_CTRL, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ctrl_read: got %02h expected 00", d); end
    send_frame(8'h42, 1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b expected 0", irq); end
    cpu_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL irq_data: got %02h expected %02h", d, e); end
`endif
  endtask

  task automatic test_dout_hold();
    logic [7:0] d;
    send_frame(8'h5A, 1);
    cpu_read(A_DATA, d);
    void'(model_pop());
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL hold_read: got %02h expected 5A", d); end
    cpu_write(A_RSVD, 8'hC3);
    repeat (4) @(negedge clk);
    checks++;
    if (dout !== 8'h5A) begin errors++; $display("FAIL dout_hold: got %02h expected 5A", dout); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    int         low_seen;
    cpu_write(A_DATA, 8'h00);
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_tx_bit: got %b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || dout !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got tx=%b dout=%02h irq=%b expected 1 00 0", tx, dout, irq);
    end
    model_q.delete();
    m_overrun = 0;
    m_frame_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    low_seen = 0;
    repeat (2 * DIV) begin
      if (tx !== 1'b1) low_seen++;
      @(negedge clk);
    end
    checks++;
    if (low_seen != 0) begin errors++; $display("FAIL tx_after_reset: low for %0d cycles expected 0", low_seen); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL status_after_reset: got %02h expected 00", d); end
    cpu_read(A_CTRL, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ctrl_after_reset: got %02h expected 00", d); end
  endtask

  initial begin
    test_reset();
    test_tx(8'h55, "tx_55");
    test_tx(8'($urandom), "tx_rand0");
    test_tx(8'($urandom), "tx_rand1");
    test_tx_busy();
    test_back_to_back();
    test_rx_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_random();
    test_ctrl_irq();
    test_dout_hold();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
